// File: rtl/palette_ram_arbiter_pkg.sv
// Shared types and default widths for the palette RAM arbiter.
// Optional INIT sweep is enabled by defining PALETTE_ARB_INIT_EN.
package palette_arb_pkg;

    localparam int unsigned PAL_ADDR_W = 8;
    localparam int unsigned PAL_DATA_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [PAL_ADDR_W-1:0] addr;
        logic [PAL_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/palette_ram_arbiter_if.sv
// CPU write channel plus external palette RAM port.
// slave = arbiter side, master = CPU/RAM environment side.
interface palette_ram_arbiter_if #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, ram_rdata,
        output cpu_wr_ready, fifo_level, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, ram_rdata,
        input  cpu_wr_ready, fifo_level, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/palette_ram_arbiter_wr_fifo.sv
// In-order CPU write FIFO of {addr, data}; DEPTH must be a power of 2.
module palette_wr_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_en,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_comb begin
        full       = (level_q == LVL_W'(DEPTH));
        empty      = (level_q == '0);
        push_ready = push_en & ~full;
        push       = push_valid & push_ready;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign level     = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/palette_ram_arbiter.sv
// Palette RAM arbiter: video reads own h_half slots, CPU writes drain otherwise.
// Define PALETTE_ARB_INIT_EN to zero-fill the RAM after reset (INIT state).
module palette_ram_arbiter
    import palette_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = PAL_ADDR_W,
    parameter int unsigned DATA_W     = PAL_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_half,
    input  logic                  cmpblk2,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic [DATA_W-1:0]     vid_data,
    output logic                  vid_valid,
    palette_ram_arbiter_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
`ifdef PALETTE_ARB_INIT_EN
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
`endif

    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [LVL_W-1:0]  level;

    palette_wr_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LVL_W  (LVL_W)
    ) u_wr_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_en    (state_q == ST_RUN),
        .push_valid (bus.cpu_wr_valid),
        .push_ready (bus.cpu_wr_ready),
        .push_addr  (bus.cpu_wr_addr),
        .push_data  (bus.cpu_wr_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .level      (level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign bus.fifo_level = level;
    assign vid_data       = vid_data_q;
    assign vid_valid      = vid_valid_q;

    // RAM port is combinational; gating on rst_n keeps it idle while reset is held.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        rd_pend_d     = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
`ifdef PALETTE_ARB_INIT_EN
        init_addr_d   = init_addr_q;
`endif
        if (!rst_n) begin
            state_d = state_q;
`ifdef PALETTE_ARB_INIT_EN
        end else if (state_q == ST_INIT) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = 1'b1;
            bus.ram_addr = init_addr_q;
            init_addr_d  = init_addr_q + ADDR_W'(1);
            if (init_addr_q == '1) state_d = ST_RUN;
`endif
        end else if (!cmpblk2 && h_half) begin
            rd_pend_d    = 1'b1;
            bus.ram_en   = 1'b1;
            bus.ram_addr = vid_addr;
        end else if (!fifo_empty) begin
            pop           = 1'b1;
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = head_addr;
            bus.ram_wdata = head_data;
        end
        vid_valid_d = rd_pend_q;
        vid_data_d  = rd_pend_q ? bus.ram_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef PALETTE_ARB_INIT_EN
            state_q     <= ST_INIT;
            init_addr_q <= '0;
`else
            state_q     <= ST_RUN;
`endif
            rd_pend_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
        end else begin
            state_q     <= state_d;
`ifdef PALETTE_ARB_INIT_EN
            init_addr_q <= init_addr_d;
`endif
            rd_pend_q   <= rd_pend_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
        end
    end

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Directed bench for palette_ram_arbiter with a behavioural sync RAM model.
module tb_palette_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       h_half;
    logic       cmpblk2;
    logic [7:0] vid_addr;
    logic [7:0] vid_data;
    logic       vid_valid;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    logic [7:0]  mem [256];
    logic [15:0] wlog [$];

    palette_ram_arbiter_if #(.FIFO_DEPTH(4), .ADDR_W(8), .DATA_W(8)) bus ();

    palette_ram_arbiter #(.FIFO_DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_half    (h_half),
        .cmpblk2   (cmpblk2),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM; also logs writes and flags writes in read slots.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
                wlog.push_back({bus.ram_addr, bus.ram_wdata});
                if (!cmpblk2 && h_half) viol++;
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input logic [7:0] a, input logic [7:0] d);
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = a;
        bus.cpu_wr_data  = d;
        tick();
    endtask

    initial begin
        logic accepted;
        int   bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.ram_rdata    = 8'h00;
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_wr_addr  = 8'h00;
        bus.cpu_wr_data  = 8'h00;
        rst_n    = 1'b0;
        h_half   = 1'b1;
        cmpblk2  = 1'b0;
        vid_addr = 8'h5A;
        tick();
        tick();
        chk("rst_vid_data",  vid_data, 8'h00);
        chk("rst_vid_valid", vid_valid, 1'b0);
        chk("rst_level",     bus.fifo_level, 3'd0);
        chk("rst_ram_en",    bus.ram_en, 1'b0);

        cmpblk2 = 1'b1;
        rst_n   = 1'b1;
        wlog.delete();
`ifdef PALETTE_ARB_INIT_EN
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (bus.cpu_wr_ready !== 1'b0) bad++;
            tick();
        end
        chk("init_ready_low", bad, 0);
        chk("init_ready_after", bus.cpu_wr_ready, 1'b1);
        chk("init_count", wlog.size(), 256);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (i >= wlog.size() || wlog[i] !== {i[7:0], 8'h00}) bad++;
        chk("init_sweep", bad, 0);
`endif
        mem[8'h5A] = 8'hE3;
        tick();
        tick();

        // Active-display read of a preloaded entry
        cmpblk2  = 1'b0;
        h_half   = 1'b1;
        vid_addr = 8'h5A;
        #1;
        chk("rd_ram_en",   bus.ram_en, 1'b1);
        chk("rd_ram_we",   bus.ram_we, 1'b0);
        chk("rd_ram_addr", bus.ram_addr, 8'h5A);
        tick();
        h_half = 1'b0;
        chk("rd_lat1_valid", vid_valid, 1'b0);
        tick();
        chk("rd_vid_data",  vid_data, 8'hE3);
        chk("rd_vid_valid", vid_valid, 1'b1);
        tick();
        chk("rd_gap_valid", vid_valid, 1'b0);
        chk("rd_gap_data",  vid_data, 8'h00);

        // Five pushes into a depth-4 FIFO while every slot is a read slot
        wlog.delete();
        h_half = 1'b1;
        for (int i = 0; i < 4; i++) push_tick(8'h20 + 8'(i), 8'h40 + 8'(i));
        bus.cpu_wr_addr = 8'h24;
        bus.cpu_wr_data = 8'h44;
        chk("full_ready", bus.cpu_wr_ready, 1'b0);
        chk("full_level", bus.fifo_level, 3'd4);
        for (int c = 0; c < 20; c++) begin
            h_half   = (c % 2 == 1);
            #1;
            accepted = bus.cpu_wr_valid && bus.cpu_wr_ready;
            tick();
            if (accepted) bus.cpu_wr_valid = 1'b0;
        end
        chk("drain_level", bus.fifo_level, 3'd0);
        chk("drain_count", wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("drain_order", (i < wlog.size()) ? wlog[i] : 16'hXXXX,
                {8'h20 + 8'(i), 8'h40 + 8'(i)});
        h_half   = 1'b1;
        vid_addr = 8'h22;
        tick();
        h_half = 1'b0;
        tick();
        chk("readback_22", vid_data, 8'h42);

        // Blanking push drains on the very next cycle
        cmpblk2 = 1'b1;
        h_half  = 1'b1;
        tick();
        tick();
        wlog.delete();
        push_tick(8'h10, 8'h1C);
        bus.cpu_wr_valid = 1'b0;
        #1;
        chk("blank_we",    bus.ram_we, 1'b1);
        chk("blank_addr",  bus.ram_addr, 8'h10);
        chk("blank_wdata", bus.ram_wdata, 8'h1C);
        tick();
        chk("blank_mem",   mem[8'h10], 8'h1C);
        chk("blank_level", bus.fifo_level, 3'd0);
        chk("blank_valid", vid_valid, 1'b0);
        chk("blank_data",  vid_data, 8'h00);
        chk("blank_wcnt",  wlog.size(), 1);

        // Simultaneous push/pop at level 2, order kept through pointer wrap
        cmpblk2 = 1'b0;
        h_half  = 1'b1;
        wlog.delete();
        push_tick(8'h30, 8'hA0);
        push_tick(8'h31, 8'hA1);
        chk("pp_level_pre", bus.fifo_level, 3'd2);
        h_half = 1'b0;
        push_tick(8'h32, 8'hA2);
        chk("pp_level_same", bus.fifo_level, 3'd2);
        for (int k = 0; k < 10; k++) push_tick(8'h33 + 8'(k), 8'hA3 + 8'(k));
        chk("pp_level_loop", bus.fifo_level, 3'd2);
        bus.cpu_wr_valid = 1'b0;
        tick();
        tick();
        chk("pp_level_end", bus.fifo_level, 3'd0);
        chk("pp_count", wlog.size(), 13);
        bad = 0;
        for (int i = 0; i < 13; i++)
            if (i >= wlog.size() || wlog[i] !== {8'h30 + 8'(i), 8'hA0 + 8'(i)}) bad++;
        chk("pp_order", bad, 0);

        // Reset with entries queued and a read in flight
        h_half = 1'b1;
        for (int i = 0; i < 3; i++) push_tick(8'h50 + 8'(i), 8'h70 + 8'(i));
        bus.cpu_wr_valid = 1'b0;
        chk("mid_level_pre", bus.fifo_level, 3'd3);
        chk("mid_valid_pre", vid_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_vid_valid", vid_valid, 1'b0);
        chk("mid_vid_data",  vid_data, 8'h00);
        chk("mid_level",     bus.fifo_level, 3'd0);
        chk("mid_ram_en",    bus.ram_en, 1'b0);
        chk("mid_ram_we",    bus.ram_we, 1'b0);
        chk("mid_ram_addr",  bus.ram_addr, 8'h00);
        chk("mid_ram_wdata", bus.ram_wdata, 8'h00);
        #2;
        cmpblk2 = 1'b1;
        rst_n   = 1'b1;
        wlog.delete();
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_nowrite", wlog.size(), 0);
        push_tick(8'h60, 8'h66);
        bus.cpu_wr_valid = 1'b0;
        tick();
        chk("post_rst_write", wlog.size(), 1);
        chk("post_rst_mem", mem[8'h60], 8'h66);

        chk("no_write_in_read_slot", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
